// File: rtl/spi_regs_pkg.sv
// Shared constants and types for the SPI target register file.
package spi_regs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] ADDR_CTRL    = 7'h00;
  localparam logic [6:0] ADDR_STATUS  = 7'h01;
  localparam logic [6:0] ADDR_SCRATCH = 7'h02;
  localparam logic [6:0] ADDR_ID      = 7'h03;

  // Command byte bit selecting read (1) or write (0)
  localparam int RW_BIT = 7;

  function automatic logic is_read(input logic [7:0] cmd);
    return cmd[RW_BIT];
  endfunction

endpackage

// File: rtl/spi_slave_regs_if.sv
// SPI header pins plus the register-side status/control signals.
interface spi_slave_regs_if;
  logic       i_SPI_NCS;
  logic       i_SPI_SCK;
  logic       i_SPI_SI;
  logic       o_SPI_SO;
  logic       o_SPI_SO_OE;
  logic [7:0] i_Status;
  logic [7:0] o_Ctrl;
  logic       o_Wr_Strobe;
  logic       o_Frame_Err;

  modport slave (
    input  i_SPI_NCS, i_SPI_SCK, i_SPI_SI, i_Status,
    output o_SPI_SO, o_SPI_SO_OE, o_Ctrl, o_Wr_Strobe, o_Frame_Err
  );

  modport master (
    output i_SPI_NCS, i_SPI_SCK, i_SPI_SI, i_Status,
    input  o_SPI_SO, o_SPI_SO_OE, o_Ctrl, o_Wr_Strobe, o_Frame_Err
  );
endinterface

// File: rtl/spi_slave_regs_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus one edge-detect flop.
// Rise/fall are single-cycle pulses derived from the synchronized level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Async,
  output logic o_Sync,
  output logic o_Rise,
  output logic o_Fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchronizer chain, then remember last level
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_Async};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign o_Sync = sync_q[STAGES-1];
  assign o_Rise = sync_q[STAGES-1] & ~prev_q;
  assign o_Fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 target giving an external initiator access to CTRL, STATUS,
// SCRATCH and ID. All pins are oversampled in the system clock domain.
module spi_slave_regs
  import spi_regs_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter logic [7:0] CTRL_RESET  = 8'h00
) (
  input  logic           i_Clock,
  input  logic           i_Rst_L,
  spi_slave_regs_if.slave bus
);

  // Synchronized pin views. NCS syncs reset to 0 so a chip select that is
  // already low out of reset never looks like a falling edge.
  logic ncs_s, ncs_rise, ncs_fall;
  logic sck_rise, sck_fall, sck_lvl_unused;
  logic si_s, si_rise_unused, si_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ncs (
    .i_Clock(i_Clock), .i_Rst_L(i_Rst_L), .i_Async(bus.i_SPI_NCS),
    .o_Sync(ncs_s), .o_Rise(ncs_rise), .o_Fall(ncs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .i_Clock(i_Clock), .i_Rst_L(i_Rst_L), .i_Async(bus.i_SPI_SCK),
    .o_Sync(sck_lvl_unused), .o_Rise(sck_rise), .o_Fall(sck_fall)
  );

  // Same depth as SCK so the sampled SI bit lines up with the detected rise
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_si (
    .i_Clock(i_Clock), .i_Rst_L(i_Rst_L), .i_Async(bus.i_SPI_SI),
    .o_Sync(si_s), .o_Rise(si_rise_unused), .o_Fall(si_fall_unused)
  );

  state_t     state_q, state_n;
  logic [3:0] cnt_q, cnt_n;      // SCK rises seen in this frame
  logic [6:0] shf_q, shf_n;      // incoming bits; full byte = {shf_q, si_s}
  logic [7:0] cmd_q, cmd_n;
  logic [6:0] rd_q, rd_n;        // remaining read bits after the one on SO
  logic       so_q, so_n;
  logic       stb_q, stb_n;
  logic       err_q, err_n;
  logic [7:0] ctrl_q, ctrl_n;
  logic [7:0] scr_q, scr_n;
  logic       armed_q, armed_n;  // NCS has been seen high since reset

  logic [7:0] in_byte;
  logic [7:0] rd_byte;

  assign in_byte = {shf_q, si_s};

  // Read data for the address in the byte completing on this rise
  always_comb begin
    rd_byte = 8'h00;
    case (in_byte[6:0])
      ADDR_CTRL:    rd_byte = ctrl_q;
      ADDR_STATUS:  rd_byte = bus.i_Status;
      ADDR_SCRATCH: rd_byte = scr_q;
      ADDR_ID:      rd_byte = ID_VALUE;
      default:      rd_byte = 8'h00;
    endcase
  end

  // Register all frame state, outputs and the register file
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shf_q   <= '0;
      cmd_q   <= '0;
      rd_q    <= '0;
      so_q    <= 1'b0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      ctrl_q  <= CTRL_RESET;
      scr_q   <= 8'h00;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      shf_q   <= shf_n;
      cmd_q   <= cmd_n;
      rd_q    <= rd_n;
      so_q    <= so_n;
      stb_q   <= stb_n;
      err_q   <= err_n;
      ctrl_q  <= ctrl_n;
      scr_q   <= scr_n;
      armed_q <= armed_n;
    end
  end

  // Frame sequencing: command byte, data byte, then ignore until deselect
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    shf_n   = shf_q;
    cmd_n   = cmd_q;
    rd_n    = rd_q;
    so_n    = so_q;
    stb_n   = 1'b0;
    err_n   = 1'b0;
    ctrl_n  = ctrl_q;
    scr_n   = scr_q;
    armed_n = armed_q | ncs_s;

    if (ncs_rise) begin
      // Deselect aborts anything in flight; only a partial frame is an error
      state_n = IDLE;
      cnt_n   = '0;
      shf_n   = '0;
      cmd_n   = '0;
      rd_n    = '0;
      so_n    = 1'b0;
      err_n   = ((state_q == CMD) && (cnt_q != 4'd0)) || (state_q == DATA);
    end else begin
      case (state_q)
        IDLE: begin
          if (ncs_fall && armed_q) begin
            state_n = CMD;
            cnt_n   = '0;
            shf_n   = '0;
            so_n    = 1'b0;
          end
        end

        CMD: begin
          if (sck_rise) begin
            cnt_n = cnt_q + 4'd1;
            shf_n = {shf_q[5:0], si_s};
            if (cnt_q == 4'd7) begin
              cmd_n   = in_byte;
              shf_n   = '0;
              state_n = DATA;
              if (is_read(in_byte)) begin
                rd_n = rd_byte[6:0];
                so_n = rd_byte[7];
              end
            end
          end
        end

        DATA: begin
          if (sck_rise) begin
            cnt_n = cnt_q + 4'd1;
            shf_n = {shf_q[5:0], si_s};
            if (cnt_q == 4'd15) begin
              state_n = DONE;
              so_n    = 1'b0;
              rd_n    = '0;
              if (!is_read(cmd_q)) begin
                case (cmd_q[6:0])
                  ADDR_CTRL: begin
                    ctrl_n = in_byte;
                    stb_n  = 1'b1;
                  end
                  ADDR_SCRATCH: begin
                    scr_n = in_byte;
                    stb_n = 1'b1;
                  end
                  default: ;
                endcase
              end
            end
          end else if (sck_fall && is_read(cmd_q) && (cnt_q != 4'd8)) begin
            // The fall right after the command byte keeps bit7 on SO
            so_n = rd_q[6];
            rd_n = {rd_q[5:0], 1'b0};
          end
        end

        DONE: ;

        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.o_SPI_SO    = so_q;
  assign bus.o_SPI_SO_OE = ~ncs_s & armed_q;
  assign bus.o_Ctrl      = ctrl_q;
  assign bus.o_Wr_Strobe = stb_q;
  assign bus.o_Frame_Err = err_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: table of full frames with a read-data scoreboard,
// plus hand sequences for aborted, over-long and reset-interrupted frames.
module tb_spi_slave_regs;

  localparam int HP = 8;  // SCK half period in system clocks

  logic clk = 1'b0;
  logic rst_n;

  spi_slave_regs_if bus ();

  spi_slave_regs #(
    .SYNC_STAGES(2),
    .ID_VALUE   (8'hA5),
    .CTRL_RESET (8'h00)
  ) dut (
    .i_Clock(clk),
    .i_Rst_L(rst_n),
    .bus    (bus)
  );

  always #20 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int stb_cnt = 0;
  int err_cnt = 0;

  logic [7:0] exp_q[$];

  // Count output pulses away from the active edge
  always @(negedge clk) begin
    if (bus.o_Wr_Strobe) stb_cnt <= stb_cnt + 1;
    if (bus.o_Frame_Err) err_cnt <= err_cnt + 1;
  end

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [7:0] status;
    logic [7:0] exp_rd;
    logic [7:0] exp_ctrl;
    int         exp_stb;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK cycle; s is SO as the initiator sees it just before the rise
  task automatic bit_x(input logic b, output logic s);
    bus.i_SPI_SI = b;
    clk_n(HP);
    s = bus.o_SPI_SO;
    bus.i_SPI_SCK = 1'b1;
    clk_n(HP);
    bus.i_SPI_SCK = 1'b0;
  endtask

  // Full frame of nb bits from v (MSB first). rx collects bits 8..15 from SO;
  // bad flags any nonzero SO outside the data byte.
  task automatic frame(input logic [23:0] v, input int nb,
                       output logic [7:0] rx, output logic bad, output logic oe);
    logic s;
    rx  = 8'h00;
    bad = 1'b0;
    bus.i_SPI_NCS = 1'b0;
    clk_n(HP);
    oe = bus.o_SPI_SO_OE;
    for (int i = 0; i < nb; i++) begin
      bit_x(v[23-i], s);
      if (i >= 8 && i < 16) rx = {rx[6:0], s};
      else if (s !== 1'b0) bad = 1'b1;
    end
    clk_n(HP);
    bus.i_SPI_NCS = 1'b1;
    clk_n(2*HP);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx, exp;
    logic       bad, oe, s;
    int         s0, e0;
    logic [23:0] pat;

    //            cmd     dat    status exp_rd exp_ctrl stb
    vt[0]  = '{8'h00, 8'h33, 8'h00, 8'h00, 8'h33, 1};
    vt[1]  = '{8'h80, 8'h00, 8'h00, 8'h33, 8'h33, 0};
    vt[2]  = '{8'h81, 8'h00, 8'h5C, 8'h5C, 8'h33, 0};
    vt[3]  = '{8'h83, 8'h00, 8'h00, 8'hA5, 8'h33, 0};
    vt[4]  = '{8'h85, 8'h00, 8'h00, 8'h00, 8'h33, 0};
    vt[5]  = '{8'h03, 8'hFF, 8'h00, 8'h00, 8'h33, 0};
    vt[6]  = '{8'h83, 8'h00, 8'h00, 8'hA5, 8'h33, 0};
    vt[7]  = '{8'h02, 8'h96, 8'h00, 8'h00, 8'h33, 1};
    vt[8]  = '{8'h82, 8'h00, 8'h00, 8'h96, 8'h33, 0};
    vt[9]  = '{8'h01, 8'h77, 8'h00, 8'h00, 8'h33, 0};
    vt[10] = '{8'h81, 8'h00, 8'hC3, 8'hC3, 8'h33, 0};
    vt[11] = '{8'h7F, 8'h12, 8'h00, 8'h00, 8'h33, 0};
    vt[12] = '{8'h80, 8'h00, 8'h00, 8'h33, 8'h33, 0};
    vt[13] = '{8'h00, 8'hA1, 8'h00, 8'h00, 8'hA1, 1};
    vt[14] = '{8'h80, 8'hFF, 8'h00, 8'hA1, 8'hA1, 0};

    bus.i_SPI_NCS = 1'b1;
    bus.i_SPI_SCK = 1'b0;
    bus.i_SPI_SI  = 1'b0;
    bus.i_Status  = 8'h00;
    rst_n = 1'b0;
    clk_n(4);
    chk("rst_so",   {7'd0, bus.o_SPI_SO},    8'h00);
    chk("rst_oe",   {7'd0, bus.o_SPI_SO_OE}, 8'h00);
    chk("rst_ctrl", bus.o_Ctrl,              8'h00);
    chk("rst_stb",  {7'd0, bus.o_Wr_Strobe}, 8'h00);
    chk("rst_err",  {7'd0, bus.o_Frame_Err}, 8'h00);
    rst_n = 1'b1;
    clk_n(10);
    chk("idle_oe", {7'd0, bus.o_SPI_SO_OE}, 8'h00);

    // Table of complete two-byte frames
    for (int i = 0; i < 15; i++) begin
      bus.i_Status = vt[i].status;
      if (vt[i].cmd[7]) exp_q.push_back(vt[i].exp_rd);
      s0 = stb_cnt;
      e0 = err_cnt;
      frame({vt[i].cmd, vt[i].dat, 8'h00}, 16, rx, bad, oe);
      if (vt[i].cmd[7]) begin
        exp = exp_q.pop_front();
        chk($sformatf("v%0d_rd", i), rx, exp);
      end
      chk($sformatf("v%0d_ctrl", i), bus.o_Ctrl, vt[i].exp_ctrl);
      chk($sformatf("v%0d_stb", i), 8'(stb_cnt - s0), 8'(vt[i].exp_stb));
      chk($sformatf("v%0d_err", i), 8'(err_cnt - e0), 8'h00);
      chk($sformatf("v%0d_so0", i), {7'd0, bad}, 8'h00);
      chk($sformatf("v%0d_oe", i), {7'd0, oe}, 8'h01);
    end

    // Select/deselect with no SCK: not an error
    e0 = err_cnt;
    bus.i_SPI_NCS = 1'b0; clk_n(HP);
    bus.i_SPI_NCS = 1'b1; clk_n(2*HP);
    chk("empty_err", 8'(err_cnt - e0), 8'h00);

    // Deselect after 3 command bits
    e0 = err_cnt;
    bus.i_SPI_NCS = 1'b0; clk_n(HP);
    for (int i = 0; i < 3; i++) bit_x(1'b0, s);
    clk_n(HP);
    bus.i_SPI_NCS = 1'b1; clk_n(2*HP);
    chk("cmd3_err", 8'(err_cnt - e0), 8'h01);

    // Deselect after 11 bits of a CTRL write
    s0 = stb_cnt;
    e0 = err_cnt;
    pat = {8'h00, 8'h5A, 8'h00};
    bus.i_SPI_NCS = 1'b0; clk_n(HP);
    for (int i = 0; i < 11; i++) bit_x(pat[23-i], s);
    clk_n(HP);
    bus.i_SPI_NCS = 1'b1; clk_n(2*HP);
    chk("abort_err",  8'(err_cnt - e0), 8'h01);
    chk("abort_stb",  8'(stb_cnt - s0), 8'h00);
    chk("abort_ctrl", bus.o_Ctrl, 8'hA1);

    // Next frame after the abort behaves normally
    s0 = stb_cnt;
    e0 = err_cnt;
    frame({8'h00, 8'h3C, 8'h00}, 16, rx, bad, oe);
    chk("post_ctrl", bus.o_Ctrl, 8'h3C);
    chk("post_stb",  8'(stb_cnt - s0), 8'h01);
    chk("post_err",  8'(err_cnt - e0), 8'h00);
    exp_q.push_back(8'h3C);
    frame({8'h80, 8'h00, 8'h00}, 16, rx, bad, oe);
    exp = exp_q.pop_front();
    chk("post_rd", rx, exp);

    // Three-byte frame: third byte ignored, SO held low
    s0 = stb_cnt;
    e0 = err_cnt;
    frame({8'h00, 8'h0F, 8'hFF}, 24, rx, bad, oe);
    chk("long_ctrl", bus.o_Ctrl, 8'h0F);
    chk("long_stb",  8'(stb_cnt - s0), 8'h01);
    chk("long_err",  8'(err_cnt - e0), 8'h00);
    chk("long_so",   {7'd0, bad}, 8'h00);

    // Reset in the middle of an ID read, released with NCS still low
    pat = {8'h83, 8'h00, 8'h00};
    bus.i_SPI_NCS = 1'b0; clk_n(HP);
    for (int i = 0; i < 10; i++) bit_x(pat[23-i], s);
    rst_n = 1'b0;
    clk_n(3);
    chk("mrst_so",   {7'd0, bus.o_SPI_SO},    8'h00);
    chk("mrst_oe",   {7'd0, bus.o_SPI_SO_OE}, 8'h00);
    chk("mrst_ctrl", bus.o_Ctrl,              8'h00);
    rst_n = 1'b1;
    clk_n(4);
    s0 = stb_cnt;
    e0 = err_cnt;
    bad = 1'b0;
    for (int i = 10; i < 24; i++) begin
      bit_x(1'b1, s);
      if (s !== 1'b0) bad = 1'b1;
    end
    chk("mrst_so_hold", {7'd0, bad}, 8'h00);
    chk("mrst_oe_hold", {7'd0, bus.o_SPI_SO_OE}, 8'h00);
    chk("mrst_ctrl2",   bus.o_Ctrl, 8'h00);
    clk_n(HP);
    bus.i_SPI_NCS = 1'b1; clk_n(2*HP);
    chk("mrst_stb", 8'(stb_cnt - s0), 8'h00);
    chk("mrst_err", 8'(err_cnt - e0), 8'h00);

    // After NCS cycles, frames work again and SCRATCH is back to zero
    exp_q.push_back(8'h00);
    frame({8'h82, 8'h00, 8'h00}, 16, rx, bad, oe);
    exp = exp_q.pop_front();
    chk("after_scr", rx, exp);
    chk("after_oe", {7'd0, oe}, 8'h01);
    s0 = stb_cnt;
    frame({8'h00, 8'h55, 8'h00}, 16, rx, bad, oe);
    chk("after_ctrl", bus.o_Ctrl, 8'h55);
    chk("after_stb", 8'(stb_cnt - s0), 8'h01);
    exp_q.push_back(8'h55);
    frame({8'h80, 8'h00, 8'h00}, 16, rx, bad, oe);
    exp = exp_q.pop_front();
    chk("after_rd", rx, exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
